// File: rtl/wb_pkg.sv
// Shared constants and types for the write-back result demux.
package wb_pkg;

    localparam int DATA_W = 16;

    typedef logic [DATA_W-1:0] data_t;

    localparam logic SEL_OUT0 = 1'b0;
    localparam logic SEL_OUT1 = 1'b1;

endpackage

// File: rtl/wb_fifo.sv
// Small circular-buffer queue with registered head, full and empty flags.
module wb_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage is cleared on reset so an idle queue presents a zero head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_demux_1x2.sv
// Routes one valid/ready result stream into one of two queued consumers.
module wb_demux_1x2
    import wb_pkg::*;
#(
    parameter int DATA_W = wb_pkg::DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    output logic              out0_valid,
    input  logic              out0_ready,
    output logic [DATA_W-1:0] out0_data,
    output logic              out1_valid,
    input  logic              out1_ready,
    output logic [DATA_W-1:0] out1_data,
    output logic              busy
);

    logic full0;
    logic full1;
    logic empty0;
    logic empty1;
    logic push0;
    logic push1;

    // Only the selected queue's registered full flag gates the producer.
    assign in_ready   = (in_sel == SEL_OUT1) ? !full1 : !full0;
    assign push0      = in_valid && in_ready && (in_sel == SEL_OUT0);
    assign push1      = in_valid && in_ready && (in_sel == SEL_OUT1);
    assign out0_valid = !empty0;
    assign out1_valid = !empty1;
    assign busy       = !empty0 || !empty1;

    wb_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_q0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push0),
        .push_data(in_data),
        .pop      (out0_ready),
        .head     (out0_data),
        .full     (full0),
        .empty    (empty0)
    );

    wb_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) u_q1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push1),
        .push_data(in_data),
        .pop      (out1_ready),
        .head     (out1_data),
        .full     (full1),
        .empty    (empty1)
    );

endmodule

// File: tb/tb_wb_demux_1x2.sv
// Directed vector bench for the 1:2 write-back demux.
module tb_wb_demux_1x2;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sel;
    logic        out0_valid;
    logic        out0_ready;
    logic [15:0] out0_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [15:0] out1_data;
    logic        busy;

    int checks = 0;
    int errors = 0;

    wb_demux_1x2 #(.DATA_W(16), .DEPTH(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out0_valid(out0_valid),
        .out0_ready(out0_ready),
        .out0_data (out0_data),
        .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .out1_data (out1_data),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        v;
        logic        sel;
        logic [15:0] d;
        logic        r0;
        logic        r1;
        logic        e0v;
        logic [15:0] e0d;
        logic        e1v;
        logic [15:0] e1d;
        logic        eir;
        logic        ebusy;
    } vec_t;

    vec_t tbl [18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic s, input logic [15:0] d,
                         input logic r0, input logic r1);
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
    endtask

    initial begin
        logic [63:0] act;
        logic [63:0] exp;
        int sent;
        int recv;
        int cyc;
        logic tog;

        // v sel data r0 r1 | o0v o0d o1v o1d in_ready busy (state before edge)
        tbl[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 16'h0F0F, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 16'hF0F0, 1'b1, 1'b1, 1'b1, 16'h0F0F, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[3]  = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'hF0F0, 1'b1, 1'b1};
        tbl[4]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 16'h0001, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 16'h0003, 1'b0, 1'b1, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 16'h00AA, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 16'h00AA, 1'b0, 1'b1};
        tbl[10] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0002, 1'b1, 16'h00AA, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h00AA, 1'b1, 1'b1};
        tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 16'h1111, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 16'h2222, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b1, 1'b1};
        tbl[15] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b1, 1'b1};
        tbl[16] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b1, 1'b1};
        tbl[17] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        #2;
        chk("reset_state", {out0_valid, out0_data, out1_valid, out1_data, in_ready, busy},
            {1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0});
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
            #2;
            act = {out0_valid, (tbl[i].e0v ? out0_data : 16'h0),
                   out1_valid, (tbl[i].e1v ? out1_data : 16'h0), in_ready, busy};
            exp = {tbl[i].e0v, tbl[i].e0d, tbl[i].e1v, tbl[i].e1d, tbl[i].eir, tbl[i].ebusy};
            chk($sformatf("vec%0d", i), act, exp);
        end

        // Reset mid-stream with queue 0 full of 0x0F0F.
        @(negedge clk);
        drive(1'b1, 1'b0, 16'h0F0F, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        chk("rst_pre_full", {out0_valid, out0_data, in_ready, busy},
            {1'b1, 16'h0F0F, 1'b0, 1'b1});
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_async", {out0_valid, out0_data, out1_valid, busy, in_ready},
            {1'b0, 16'h0, 1'b0, 1'b0, 1'b1});
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #2;
        chk("rst_after", {out0_valid, out1_valid, busy, in_ready}, {4'b0001});

        // Ten back-to-back pushes with a toggling consumer.
        sent = 0;
        recv = 0;
        cyc  = 0;
        tog  = 1'b1;
        while (recv < 10 && cyc < 200) begin
            @(negedge clk);
            drive(sent < 10, 1'b0, 16'(sent), tog, 1'b0);
            #2;
            if (out0_valid && out0_ready) begin
                chk($sformatf("wrap_pop%0d", recv), 64'(out0_data), 64'(recv));
                recv++;
            end
            if (in_valid && in_ready) begin
                sent++;
            end
            tog = ~tog;
            cyc++;
        end
        chk("wrap_count", 64'(recv), 64'd10);
        @(negedge clk);
        drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        #2;
        chk("wrap_idle", {out0_valid, busy}, {2'b00});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
